// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one 8N1 UART transmit line between
//               N_REQ byte streams. It holds the grant for a multi-byte packet
//               and contains the serializer.
//               Optional: define UART_ARB_TIMEOUT_EN to drop a stalled lock.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int BAUD_DIV     = 434,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 tx_o
);

    localparam int c_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_BAUD_W = $clog2(BAUD_DIV);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_IDX_W-1:0]    r_gidx, w_gidx_nxt;
    logic [c_IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic                  r_lock, w_lock_nxt;
    logic [7:0]            r_shift, w_shift_nxt;
    logic [c_BAUD_W-1:0]   r_baud, w_baud_nxt;
    logic [2:0]            r_bit, w_bit_nxt;
    logic                  r_tx, w_tx_nxt;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOCK_TIMEOUT - 1);
    logic [c_TO_W-1:0]     r_to, w_to_nxt;
`else
    logic                  w_unused_cfg;
    assign w_unused_cfg = (LOCK_TIMEOUT != 0);
`endif

    logic [c_IDX_W-1:0]    w_pick;
    logic [c_IDX_W-1:0]    w_ptr_inc;
    logic [N_REQ-1:0]      w_grant_oh;
    logic                  w_gvalid;
    logic                  w_glast;
    logic [7:0]            w_gdata;
    logic                  w_baud_end;

    // Scan downwards so the lowest offset from the pointer wins the final write.
    always_comb begin
        int j;
        w_pick = r_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(r_ptr) + i) % N_REQ;
            if (req_valid_i[j]) begin
                w_pick = c_IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_gvalid   = 1'b0;
        w_glast    = 1'b0;
        w_gdata    = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gidx == c_IDX_W'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_gvalid      = req_valid_i[i];
                w_glast       = req_last_i[i];
                w_gdata       = req_data_i[8*i +: 8];
            end
        end
    end

    assign w_ptr_inc  = (r_gidx == c_IDX_LAST) ? '0 : r_gidx + 1'b1;
    assign w_baud_end = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_nxt    = '0;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (|req_valid_i) begin
                    w_gidx_nxt  = w_pick;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_tx_nxt = 1'b1;
                if (w_gvalid) begin
                    w_shift_nxt = w_gdata;
                    w_lock_nxt  = ~w_glast;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end else if (!r_lock) begin
                    w_state_nxt = S_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (r_to == c_TO_LAST) begin
                    w_lock_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to + 1'b1;
`endif
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        // Pre-shift so the next bit is always at r_shift[1].
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_lock) begin
                        w_state_nxt = S_GRANT;
                    end else begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_lock  <= 1'b0;
            r_shift <= 8'h00;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to <= '0;
        end else begin
            r_to <= w_to_nxt;
        end
    end
`endif

    assign req_ready_o = (r_state == S_GRANT) ? w_grant_oh : '0;
    assign grant_o     = (r_state != S_IDLE) ? w_grant_oh : '0;
    assign busy_o      = (r_state != S_IDLE);
    assign tx_o        = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (N_REQ=2, BAUD_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int B  = 4;
    localparam int LT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   valid = '0;
    logic [15:0]  data  = '0;
    logic [1:0]   last  = '0;
    logic [1:0]   ready;
    logic [1:0]   grant;
    logic         busy;
    logic         tx;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int busy_cnt  = 0;
    int ready_cnt = 0;

    int         hs_idx[$];
    logic [7:0] hs_byte[$];
    int         hs_cyc[$];

    uart_tx_arbiter #(
        .N_REQ        (N),
        .BAUD_DIV     (B),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_last_i  (last),
        .req_ready_o (ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .tx_o        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Transaction-level reference: a phase, the owner, and the elapsed frame time.
    typedef enum int {M_IDLE, M_GRANT, M_FRAME} mph_t;
    mph_t       m_ph   = M_IDLE;
    int         m_own  = 0;
    int         m_ptr  = 0;
    int         m_t    = 0;
    int         m_wait = 0;
    bit         m_lock = 1'b0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = M_IDLE; m_own = 0; m_ptr = 0; m_t = 0; m_wait = 0; m_lock = 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (valid != 2'b00) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (valid[(m_ptr + i) % N]) m_own = (m_ptr + i) % N;
                    m_ph = M_GRANT;
                    m_wait = 0;
                end
                M_GRANT: begin
                    if (valid[m_own]) begin
                        m_byte = data[8*m_own +: 8];
                        m_lock = !last[m_own];
                        m_t = 0;
                        m_ph = M_FRAME;
                    end else if (!m_lock) begin
                        m_ph = M_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else begin
                        m_wait++;
                        if (m_wait == LT) begin
                            m_lock = 1'b0;
                            m_ptr = (m_own + 1) % N;
                            m_ph = M_IDLE;
                        end
                    end
`endif
                end
                M_FRAME: begin
                    m_t++;
                    if (m_t == 10 * B) begin
                        if (m_lock) begin
                            m_ph = M_GRANT;
                            m_wait = 0;
                        end else begin
                            m_ptr = (m_own + 1) % N;
                            m_ph = M_IDLE;
                        end
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[k];
    endfunction

    always @(negedge clk) begin
        logic [1:0] e_ready, e_grant;
        logic       e_busy, e_tx;
        if (chk_en) begin
            e_grant = (m_ph != M_IDLE) ? (2'b01 << m_own) : 2'b00;
            e_ready = (m_ph == M_GRANT) ? (2'b01 << m_own) : 2'b00;
            e_busy  = (m_ph != M_IDLE);
            e_tx    = (m_ph == M_FRAME) ? frame_bit(m_byte, m_t / B) : 1'b1;
            tests++;
            if ({ready, grant, busy, tx} !== {e_ready, e_grant, e_busy, e_tx}) begin
                fails++;
                $display("FAIL cycle_%0d: got ready=%b grant=%b busy=%b tx=%b, required ready=%b grant=%b busy=%b tx=%b",
                         cyc, ready, grant, busy, tx, e_ready, e_grant, e_busy, e_tx);
            end
            if (busy === 1'b1) busy_cnt++;
            if (ready != 2'b00) ready_cnt++;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (valid[i] && ready[i]) begin
                        hs_idx.push_back(i);
                        hs_byte.push_back(data[8*i +: 8]);
                        hs_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; last = '0; data = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_hs(input int k, input int max, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ready[k] && valid[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
        tick(1);
    endtask

    // Called just after the handshake edge; samples each bit in its first cycle.
    task automatic capture(output logic [9:0] bits);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            bits[j] = tx;
            repeat (B - 1) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int base;
        int exp_idx[4];
        int exp_b[4];

        tick(1);
        chk_en = 1'b1;

        // Reset / idle state and a single 0xA5 frame.
        do_reset();
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", ready, 0);
        check("reset_grant", grant, 0);
        check("reset_busy", busy, 0);
        tick(1);
        busy_cnt = 0; ready_cnt = 0;
        data[7:0] = 8'hA5; last[0] = 1'b1; valid[0] = 1'b1;
        wait_hs(0, 10, "a5_handshake");
        valid[0] = 1'b0;
        capture(bits);
        check("a5_bits", bits, 10'b1101001010);
        tick(5);
        check("a5_busy_cycles", busy_cnt, 41);
        check("a5_ready_cycles", ready_cnt, 1);
        check("a5_idle_after", busy, 0);

        // Two continuous single-byte requesters alternate.
        do_reset();
        base = hs_idx.size();
        data = {8'h31, 8'h30}; last = 2'b11; valid = 2'b11;
        for (int i = 0; i < 400; i++) begin
            if (hs_idx.size() >= base + 4) break;
            @(posedge clk);
        end
        #1;
        valid = 2'b00;
        check("rr_handshakes", hs_idx.size() - base, 4);
        if (hs_idx.size() >= base + 4) begin
            exp_idx = '{0, 1, 0, 1};
            for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), hs_idx[base + i], exp_idx[i]);
            for (int i = 1; i < 4; i++) check($sformatf("rr_spacing_%0d", i), hs_cyc[base + i] - hs_cyc[base + i - 1], 42);
        end
        tick(50);
        check("rr_idle_after", busy, 0);

        // Locked 3-byte packet from req1 while req0 waits.
        do_reset();
        base = hs_idx.size();
        data[15:8] = 8'h11; last[1] = 1'b0; valid[1] = 1'b1;
        tick(1);
        data[7:0] = 8'h55; last[0] = 1'b1; valid[0] = 1'b1;
        wait_hs(1, 10, "pkt_hs_11");
        data[15:8] = 8'h22;
        wait_hs(1, 60, "pkt_hs_22");
        data[15:8] = 8'h33; last[1] = 1'b1;
        wait_hs(1, 60, "pkt_hs_33");
        valid[1] = 1'b0;
        wait_hs(0, 60, "pkt_hs_req0");
        valid[0] = 1'b0;
        tick(45);
        check("pkt_handshakes", hs_idx.size() - base, 4);
        if (hs_idx.size() >= base + 4) begin
            exp_idx = '{1, 1, 1, 0};
            exp_b   = '{8'h11, 8'h22, 8'h33, 8'h55};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("pkt_owner_%0d", i), hs_idx[base + i], exp_idx[i]);
                check($sformatf("pkt_byte_%0d", i), hs_byte[base + i], exp_b[i]);
            end
            check("pkt_spacing_1", hs_cyc[base + 1] - hs_cyc[base], 41);
            check("pkt_spacing_2", hs_cyc[base + 2] - hs_cyc[base + 1], 41);
            check("pkt_spacing_3", hs_cyc[base + 3] - hs_cyc[base + 2], 42);
        end

        // Reset in the middle of DATA, then a clean frame.
        do_reset();
        data[7:0] = 8'h3C; last[0] = 1'b1; valid[0] = 1'b1;
        wait_hs(0, 10, "mid_hs_3c");
        valid[0] = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant, 0);
        tick(1);
        data[7:0] = 8'h96; valid[0] = 1'b1;
        wait_hs(0, 10, "mid_hs_96");
        valid[0] = 1'b0;
        capture(bits);
        check("mid_96_bits", bits, 10'b1100101100);
        tick(5);

        // Valid withdrawn during an unlocked GRANT.
        do_reset();
        data = {8'h5A, 8'hC3}; last = 2'b11; valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        @(negedge clk);
        check("drop_grant", grant, 2'b01);
        check("drop_ready", ready, 2'b01);
        tick(1);
        @(negedge clk);
        check("drop_busy", busy, 0);
        check("drop_grant_idle", grant, 0);
        tick(1);
        base = hs_idx.size();
        valid = 2'b11;
        wait_hs(0, 10, "drop_ptr_kept");
        valid = 2'b00;
        tick(45);
        if (hs_idx.size() > base) check("drop_first_owner", hs_idx[base], 0);
        check("drop_idle_after", busy, 0);

        // Stalled lock from req1 with req0 pending.
        do_reset();
        base = hs_idx.size();
        data[15:8] = 8'h77; last[1] = 1'b0; valid[1] = 1'b1;
        tick(1);
        data[7:0] = 8'h44; last[0] = 1'b1; valid[0] = 1'b1;
        wait_hs(1, 10, "lock_hs_77");
        valid[1] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wait_hs(0, 100, "lock_timeout_hs");
        valid[0] = 1'b0;
        if (hs_idx.size() >= base + 2) begin
            check("lock_timeout_owner", hs_idx[base + 1], 0);
            check("lock_timeout_spacing", hs_cyc[base + 1] - hs_cyc[base], 10 * B + 2 + LT);
        end
        tick(45);
        check("lock_timeout_idle", busy, 0);
`else
        tick(200);
        @(negedge clk);
        check("lock_forever_hs", hs_idx.size() - base, 1);
        check("lock_forever_grant", grant, 2'b10);
        check("lock_forever_busy", busy, 1);
`endif
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
